doppler_gate_sequencer: RTL
===========================

// Module: doppler_gate_sequencer
// PURPOSE
//  Per-PRF sequencer for the pulsed-Doppler I/Q demodulator: fires the transmit burst, waits the range-gate delay,
//  enables the demodulator/accumulator for the gate length, then captures its 64-bit {Q,I} sum for the downstream
//  consumer over a valid/ready handshake. Sits between the control registers and the demodulator datapath.
// PARAMETERS
//  CNT_W      16     width of all timing counters and timing inputs
//  IQ_W       64     width of captured accumulator word ({Q[63:32], I[31:0]})
// PORTS
//  clk         in   1      system clock; all state on rising edge
//  reset       in   1      asynchronous, active-high reset
//  start       in   1      begin one PRF sequence (sampled in IDLE only)
//  abort       in   1      synchronous abort to IDLE
//  freq_cfg    in   2      carrier select (11=8MHz,10=4MHz,01=2MHz), latched at start
//  tx_cycles   in   CNT_W  transmit burst length, clocks (0 treated as 1)
//  gate_delay  in   CNT_W  clocks from burst end to gate open (0 = none)
//  gate_len    in   CNT_W  gate/integration length, clocks (0 treated as 1)
//  prf_period  in   CNT_W  clocks per PRF, counted from first TX cycle
//  iq_in       in   IQ_W   demodulator accumulator output
//  freqSel     out  2      carrier select to demodulator
//  tx_burst    out  1      transmit gate
//  demod_enable out 1      demodulator enable
//  demod_reset out  1      demodulator clear
//  iq_out      out  IQ_W   captured I/Q word
//  iq_valid    out  1      iq_out holds unread data
//  iq_ready    in   1      consumer accepts iq_out
//  busy        out  1      state != IDLE
//  overrun     out  1      sticky: capture dropped or PRF too short
// BEHAVIOUR
//  - Reset: state=IDLE, all outputs 0, freqSel=2'b11, counters 0, overrun=0.
//  - Timing inputs and freq_cfg latched on start; changes mid-sequence ignored.
//  - States: IDLE -> TX -> DELAY -> INTEG -> DUMP -> WAIT_PRF -> IDLE.
//  - IDLE: start=1 at edge N -> TX from N+1.
//  - TX: tx_burst=1 and demod_reset=1 for tx_cycles clocks; prf counter=0 in first TX cycle, +1 every cycle after.
//  - DELAY: gate_delay clocks, all gates low; gate_delay=0 skips directly TX->INTEG.
//  - INTEG: demod_enable=1 exactly gate_len clocks; demod_reset=0.
//  - DUMP: one cycle, demod_enable=0; if iq_valid=0 or (iq_valid & iq_ready) same cycle, iq_out<=iq_in and
//    iq_valid<=1; else new word dropped, iq_out held, overrun<=1.
//  - Handshake: iq_valid stays 1 until a cycle with iq_ready=1, then clears next edge (unless DUMP reloads it);
//    iq_out stable while iq_valid=1. Independent of state.
//  - WAIT_PRF: leave when prf counter == prf_period-1 -> IDLE. If counter already >= prf_period-1 on DUMP exit,
//    overrun<=1 and go straight to IDLE.
//  - abort (any state): next edge IDLE, tx_burst/demod_enable/demod_reset=0; iq_out/iq_valid/overrun untouched.
//    abort has priority over start in the same cycle.
//  - overrun clears only on reset. busy=1 in every state except IDLE.
//  - Counters saturate, never wrap; all compares on CNT_W-bit unsigned values.
// CONFIGURATION
//  DOPPLER_SEQ_FREERUN_EN defined: WAIT_PRF exits to TX (not IDLE), repeating every prf_period clocks
//    while start=1 is held; start=0 at PRF end -> IDLE. Timing inputs re-latched at each TX entry.
//  Not defined: one sequence per start pulse; start level while busy ignored.
// TESTING
//  1 start pulse, tx=4, delay=10, len=20, prf=100 -> tx_burst hi 4 clks from N+1, demod_enable hi clks 15..34 after TX, iq_valid hi once.
//  2 iq_in=64'h0000_0123_FFFF_FF00, iq_ready=1 -> iq_out equals value one clk after DUMP, iq_valid pulses 1 clk.
//  3 iq_ready=0, two sequences -> first word held, overrun=1, second word never visible.
//  4 prf=30 with tx=4,delay=10,len=20 -> overrun=1, IDLE right after DUMP.
//  5 abort mid-INTEG, then reset asserted mid-TX -> gates low next clk; reset zeroes all outputs asynchronously.
//  6 FREERUN_EN, start held, prf=100 -> tx_burst rising edges exactly 100 clks apart; drop start -> IDLE at PRF end.

Source files
------------

// File: rtl/doppler_gate_sequencer.sv
// Per-PRF sequencer for the pulsed-Doppler I/Q demodulator: TX burst, range-gate delay, integration, {Q,I} capture.
// Optional free-running PRF repetition is enabled by defining DOPPLER_SEQ_FREERUN_EN.
module doppler_gate_sequencer #(
  parameter int CNT_W = 16,
  parameter int IQ_W  = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [1:0]       freq_cfg,
  input  logic [CNT_W-1:0] tx_cycles,
  input  logic [CNT_W-1:0] gate_delay,
  input  logic [CNT_W-1:0] gate_len,
  input  logic [CNT_W-1:0] prf_period,
  input  logic [IQ_W-1:0]  iq_in,
  output logic [1:0]       freqSel,
  output logic             tx_burst,
  output logic             demod_enable,
  output logic             demod_reset,
  output logic [IQ_W-1:0]  iq_out,
  output logic             iq_valid,
  input  logic             iq_ready,
  output logic             busy,
  output logic             overrun
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_TX,
    S_DELAY,
    S_INTEG,
    S_DUMP,
    S_WAIT_PRF
  } state_t;

  state_t state, state_nxt;

  logic [CNT_W-1:0] tx_len_q, delay_q, len_q, prf_q;
  logic [CNT_W-1:0] phase_cnt, prf_cnt;
  logic [CNT_W-1:0] prf_last;
  logic [1:0]       freq_q;
  logic             latch_cfg, capture, drop, prf_short;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    sat_inc = (v == {CNT_W{1'b1}}) ? v : v + ONE;
  endfunction

  function automatic logic [CNT_W-1:0] min_one(input logic [CNT_W-1:0] v);
    min_one = (v == '0) ? ONE : v;
  endfunction

  // prf_period of 0 wraps to all-ones, i.e. the longest possible PRF
  assign prf_last = prf_q - ONE;

  always_comb begin
    state_nxt = state;
    latch_cfg = 1'b0;
    capture   = 1'b0;
    drop      = 1'b0;
    prf_short = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_nxt = S_TX;
          latch_cfg = 1'b1;
        end
      end
      S_TX: begin
        if (phase_cnt == tx_len_q - ONE)
          state_nxt = (delay_q == '0) ? S_INTEG : S_DELAY;
      end
      S_DELAY: begin
        if (phase_cnt == delay_q - ONE)
          state_nxt = S_INTEG;
      end
      S_INTEG: begin
        if (phase_cnt == len_q - ONE)
          state_nxt = S_DUMP;
      end
      S_DUMP: begin
        if (!iq_valid || iq_ready) capture = 1'b1;
        else                       drop    = 1'b1;
        if (prf_cnt >= prf_last) begin
          prf_short = 1'b1;
          state_nxt = S_IDLE;
        end else begin
          state_nxt = S_WAIT_PRF;
        end
      end
      S_WAIT_PRF: begin
        if (prf_cnt == prf_last) begin
`ifdef DOPPLER_SEQ_FREERUN_EN
          if (start) begin
            state_nxt = S_TX;
            latch_cfg = 1'b1;
          end else begin
            state_nxt = S_IDLE;
          end
`else
          state_nxt = S_IDLE;
`endif
        end
      end
      default: state_nxt = S_IDLE;
    endcase
    // Abort wins over everything, including a DUMP-cycle capture
    if (abort) begin
      state_nxt = S_IDLE;
      latch_cfg = 1'b0;
      capture   = 1'b0;
      drop      = 1'b0;
      prf_short = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      phase_cnt <= '0;
      prf_cnt   <= '0;
    end else begin
      state     <= state_nxt;
      phase_cnt <= (state_nxt != state) ? '0 : sat_inc(phase_cnt);
      if (latch_cfg)           prf_cnt <= '0;
      else if (state != S_IDLE) prf_cnt <= sat_inc(prf_cnt);
      else                     prf_cnt <= '0;
    end
  end

  // Configuration snapshot taken on every TX entry
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_len_q <= ONE;
      delay_q  <= '0;
      len_q    <= ONE;
      prf_q    <= '0;
      freq_q   <= 2'b11;
    end else if (latch_cfg) begin
      tx_len_q <= min_one(tx_cycles);
      delay_q  <= gate_delay;
      len_q    <= min_one(gate_len);
      prf_q    <= prf_period;
      freq_q   <= freq_cfg;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      iq_out   <= '0;
      iq_valid <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      if (capture) begin
        iq_out   <= iq_in;
        iq_valid <= 1'b1;
      end else if (iq_valid && iq_ready) begin
        iq_valid <= 1'b0;
      end
      if (drop || prf_short)
        overrun <= 1'b1;
    end
  end

  assign freqSel      = freq_q;
  assign tx_burst     = (state == S_TX);
  assign demod_reset  = (state == S_TX);
  assign demod_enable = (state == S_INTEG);
  assign busy         = (state != S_IDLE);

endmodule
